// File: rtl/parity_tx_pkg.sv
// Shared types and frame constants for the even-parity serial transmitter.
// Latency: n/a (types only). Backpressure: n/a.
// Build option PARITY_SERIAL_TX_PARITY_EN adds the PARITY state and widens the frame to 11 bits.
package parity_tx_pkg;

   localparam int DATA_BITS = 8;

`ifdef PARITY_SERIAL_TX_PARITY_EN
   localparam int FRAME_BITS = 11;
`else
   localparam int FRAME_BITS = 10;
`endif

   // Fixed 3-bit codes so the encoding does not shift when PARITY is compiled out.
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
`ifdef PARITY_SERIAL_TX_PARITY_EN
      PARITY = 3'd3,
`endif
      STOP   = 3'd4
   } state_t;

   function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
      return ^d;
   endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Bit-time divider: tick_o pulses on the last clock of every CLKS_PER_BIT-cycle bit time.
// Latency: tick_o is decoded from the registered count, CLKS_PER_BIT cycles after clear_i drops.
// Backpressure: none; clear_i restarts the count from zero on the next edge.
module baud_tick_gen #(
   parameter int CLKS_PER_BIT = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear_i,
   output logic tick_o
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] cnt_q;

   // With CLKS_PER_BIT=1 the count is pinned at 0 and every cycle is a tick.
   assign tick_o = (cnt_q == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (clear_i || tick_o) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

endmodule

// File: rtl/parity_serial_tx.sv
// Async-serial framer: start + 8 data (LSB first) [+ even parity with PARITY_SERIAL_TX_PARITY_EN] + stop.
// Latency: start bit on tx_o the cycle after the accepting edge; ready_o low for one whole frame.
// Backpressure: ready_o high only in IDLE; data_i/valid_i ignored while a frame is in flight.
module parity_serial_tx
   import parity_tx_pkg::*;
#(
   parameter int CLKS_PER_BIT = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] data_i,
   input  logic       valid_i,
   output logic       ready_o,
   output logic       tx_o,
   output logic       busy_o,
   output logic       parity_o
);

   localparam logic [2:0] LAST_IDX = 3'(DATA_BITS - 1);

   state_t                 state_q, state_d;
   logic [DATA_BITS-1:0]   shreg_q, shreg_d;
   logic [2:0]             idx_q, idx_d;
   logic                   tx_q, tx_d;
   logic                   tick;
   logic                   tick_clear;

`ifdef PARITY_SERIAL_TX_PARITY_EN
   logic                   par_q, par_d;
`endif

   // The counter is held at zero in IDLE so START always gets a full bit time.
   assign tick_clear = (state_q == IDLE) || (state_d != state_q);

   baud_tick_gen #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_baud_tick_gen (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear_i (tick_clear),
      .tick_o  (tick)
   );

   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      idx_d   = idx_q;
`ifdef PARITY_SERIAL_TX_PARITY_EN
      par_d   = par_q;
`endif
      case (state_q)
         IDLE: begin
            if (valid_i) begin
               state_d = START;
               shreg_d = data_i;
               idx_d   = '0;
`ifdef PARITY_SERIAL_TX_PARITY_EN
               par_d   = even_parity(data_i);
`endif
            end
         end
         START: begin
            if (tick) begin
               state_d = DATA;
            end
         end
         DATA: begin
            if (tick) begin
               if (idx_q == LAST_IDX) begin
`ifdef PARITY_SERIAL_TX_PARITY_EN
                  state_d = PARITY;
`else
                  state_d = STOP;
`endif
               end else begin
                  idx_d   = idx_q + 3'd1;
                  shreg_d = shreg_q >> 1;
               end
            end
         end
`ifdef PARITY_SERIAL_TX_PARITY_EN
         PARITY: begin
            if (tick) begin
               state_d = STOP;
            end
         end
`endif
         STOP: begin
            if (tick) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // tx_o is registered, so the line level is chosen from where the FSM is going next.
   always_comb begin
      tx_d = 1'b1;
      case (state_d)
         IDLE:    tx_d = 1'b1;
         START:   tx_d = 1'b0;
         DATA:    tx_d = shreg_d[0];
`ifdef PARITY_SERIAL_TX_PARITY_EN
         PARITY:  tx_d = par_d;
`endif
         STOP:    tx_d = 1'b1;
         default: tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         shreg_q <= '0;
         idx_q   <= '0;
         tx_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         idx_q   <= idx_d;
         tx_q    <= tx_d;
      end
   end

`ifdef PARITY_SERIAL_TX_PARITY_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         par_q <= 1'b0;
      end else begin
         par_q <= par_d;
      end
   end

   assign parity_o = par_q;
`else
   assign parity_o = 1'b0;
`endif

   assign ready_o = (state_q == IDLE);
   assign busy_o  = (state_q != IDLE);
   assign tx_o    = tx_q;

endmodule
